// File: rtl/param_stack_if.sv
// Handshake/data bundle between the control unit and the param_stack LIFO.
// Master drives push/pop/din/clr_err; slave returns the registered stack status.
// max_count is present only when STACK_WATERMARK_EN is defined.
interface param_stack_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 5
);
    logic               push;
    logic               pop;
    logic               clr_err;
    logic [WIDTH-1:0]   din;
    logic [WIDTH-1:0]   dout;
    logic [COUNT_W-1:0] count;
    logic               empty;
    logic               full;
    logic               overflow;
    logic               underflow;
`ifdef STACK_WATERMARK_EN
    logic [COUNT_W-1:0] max_count;

    modport master (
        output push, pop, clr_err, din,
        input  dout, count, empty, full, overflow, underflow, max_count
    );

    modport slave (
        input  push, pop, clr_err, din,
        output dout, count, empty, full, overflow, underflow, max_count
    );
`else
    modport master (
        output push, pop, clr_err, din,
        input  dout, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err, din,
        output dout, count, empty, full, overflow, underflow
    );
`endif
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO with registered top-of-stack, replace-top and sticky error flags.
// Latency: every output reflects a request one clock after the request edge.
// Backpressure: none; push when full / pop when empty are dropped and flagged.
// Optional macro STACK_WATERMARK_EN adds max_count (highest occupancy since reset).
module param_stack #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int COUNT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    param_stack_if.slave bus
);
    // Storage index width; count itself needs one more value (DEPTH) than the index.
    localparam int                 AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] ONE_CNT  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] TWO_CNT  = COUNT_W'(2);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_dout;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_empty;
    logic               w_full;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_idx;
    logic [AW-1:0]      w_rd_idx;
    logic [COUNT_W-1:0] w_next_count;
    logic [WIDTH-1:0]   w_next_dout;
    logic               w_ovf_evt;
    logic               w_unf_evt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Decode the request against the pre-edge count into write, next-count and next-top.
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_idx     = AW'(r_count);
        w_rd_idx     = AW'(r_count - TWO_CNT);
        w_next_count = r_count;
        w_next_dout  = r_dout;
        w_ovf_evt    = 1'b0;
        w_unf_evt    = 1'b0;
        case ({bus.push, bus.pop})
            2'b11: begin
                // Replace top; on an empty stack this degenerates to a plain push.
                w_wr_en     = 1'b1;
                w_next_dout = bus.din;
                if (w_empty) begin
                    w_wr_idx     = '0;
                    w_next_count = ONE_CNT;
                end else begin
                    w_wr_idx = AW'(r_count - ONE_CNT);
                end
            end
            2'b10: begin
                if (w_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_wr_en      = 1'b1;
                    w_next_count = r_count + ONE_CNT;
                    w_next_dout  = bus.din;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_next_count = r_count - ONE_CNT;
                    // The new top sits two below the old count; nothing left means 0.
                    w_next_dout  = (r_count == ONE_CNT) ? '0 : r_mem[w_rd_idx];
                end
            end
            default: ;
        endcase
    end

    // Storage array is deliberately not reset; a write in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[w_wr_idx] <= bus.din;
        end
    end

    // Occupancy, registered top and sticky flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_next_count;
            r_dout      <= w_next_dout;
            r_overflow  <= w_ovf_evt | (r_overflow  & ~bus.clr_err);
            r_underflow <= w_unf_evt | (r_underflow & ~bus.clr_err);
        end
    end

`ifdef STACK_WATERMARK_EN
    logic [COUNT_W-1:0] r_max_count;

    // High-water mark tracks the post-edge count; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_max_count <= '0;
        end else if (w_next_count > r_max_count) begin
            r_max_count <= w_next_count;
        end
    end

    assign bus.max_count = r_max_count;
`endif

    assign bus.dout      = r_dout;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
